// File: rtl/lap_recall_buffer.sv
// lap_recall_buffer: circular store of the last DEPTH lap times with a
// scrollable recall view. The display fields are registered. In SHOW they hold
// the selected lap; in LIVE they are zero.
module lap_recall_buffer #(
    parameter int DEPTH   = 8,
    parameter int SEC_W   = 6,
    parameter int TENTH_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lap_store,
    input  logic [TENTH_W-1:0]           tenth_sec_in,
    input  logic [SEC_W-1:0]             sec_in,
    input  logic                         recall_next,
    input  logic                         recall_exit,
    input  logic                         clear,
    output logic [TENTH_W-1:0]           tenth_sec_out,
    output logic [SEC_W-1:0]             sec_out,
    output logic [$clog2(DEPTH+1)-1:0]   lap_idx,
    output logic [$clog2(DEPTH+1)-1:0]   lap_count,
    output logic                         buf_full,
    output logic                         valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {
        LIVE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0]    r_rd_ptr, w_rd_ptr_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic [CNT_W-1:0]    r_idx, w_idx_nxt;
    logic [TENTH_W-1:0]  r_tenth, w_tenth_nxt;
    logic [SEC_W-1:0]    r_sec, w_sec_nxt;
    logic                w_we;
    logic [PTR_W-1:0]    w_newest;

    logic [TENTH_W-1:0]  r_mem_tenth [DEPTH];
    logic [SEC_W-1:0]    r_mem_sec   [DEPTH];

    assign w_newest = r_wr_ptr - 1'b1;

    // Storage write; contents are left unreset on purpose
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_tenth[r_wr_ptr] <= tenth_sec_in;
            r_mem_sec[r_wr_ptr]   <= sec_in;
        end
    end

    // Next-state, pointer and display selection; priority clear > store > exit > next
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_idx_nxt    = r_idx;
        w_tenth_nxt  = r_tenth;
        w_sec_nxt    = r_sec;
        w_we         = 1'b0;

        if (clear) begin
            w_state_nxt  = LIVE;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_idx_nxt    = '0;
            w_tenth_nxt  = '0;
            w_sec_nxt    = '0;
        end else if (lap_store) begin
            w_we         = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            w_count_nxt  = (r_count == FULL_CNT) ? r_count : r_count + 1'b1;
            // In SHOW, jump to the slot being written so an overwritten entry is never shown;
            // the display fields are fed from the inputs because the slot is written this same edge
            if (r_state == SHOW) begin
                w_rd_ptr_nxt = r_wr_ptr;
                w_idx_nxt    = w_count_nxt;
                w_tenth_nxt  = tenth_sec_in;
                w_sec_nxt    = sec_in;
            end
        end else if (recall_exit) begin
            w_state_nxt = LIVE;
            w_idx_nxt   = '0;
            w_tenth_nxt = '0;
            w_sec_nxt   = '0;
        end else if (recall_next) begin
            if (r_state == LIVE) begin
                if (r_count != '0) begin
                    w_state_nxt  = SHOW;
                    w_rd_ptr_nxt = w_newest;
                    w_idx_nxt    = r_count;
                end
            end else if (r_idx <= ONE_CNT) begin
                w_rd_ptr_nxt = w_newest;
                w_idx_nxt    = r_count;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr - 1'b1;
                w_idx_nxt    = r_idx - 1'b1;
            end
            if (w_state_nxt == SHOW) begin
                w_tenth_nxt = r_mem_tenth[w_rd_ptr_nxt];
                w_sec_nxt   = r_mem_sec[w_rd_ptr_nxt];
            end
        end
    end

    // State, pointer, count and display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= LIVE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_tenth  <= '0;
            r_sec    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_idx    <= w_idx_nxt;
            r_tenth  <= w_tenth_nxt;
            r_sec    <= w_sec_nxt;
        end
    end

    assign tenth_sec_out = r_tenth;
    assign sec_out       = r_sec;
    assign lap_idx       = r_idx;
    assign lap_count     = r_count;
    assign buf_full      = (r_count == FULL_CNT);
    assign valid         = (r_state == SHOW);

endmodule

// File: doc/lap_recall_buffer.md
Name: lap_recall_buffer

Overview:
- Reader-side counterpart to the single-entry lap capture path.
- Stores the last DEPTH lap times (seconds + tenths) in a circular buffer on lap_store pulses.
- User scrolls through stored laps with recall_next for display on the 7-segment path.
- Sits between the stopwatch counter and the display mux; valid selects recalled lap over live time.

Parameters:
DEPTH, 8, number of lap entries held (power of 2, >=2)
SEC_W, 6, seconds field width
TENTH_W, 4, tenths field width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
lap_store  input  1  1-cycle pulse: write tenth_sec_in/sec_in as newest lap
tenth_sec_in  input  TENTH_W  current tenths from counter
sec_in  input  SEC_W  current seconds from counter
recall_next  input  1  1-cycle pulse: enter recall / step to next older lap
recall_exit  input  1  1-cycle pulse: leave recall
clear  input  1  1-cycle pulse: empty buffer
tenth_sec_out  output  TENTH_W  recalled lap tenths (registered)
sec_out  output  SEC_W  recalled lap seconds (registered)
lap_idx  output  $clog2(DEPTH+1)  displayed lap, 1 = oldest held, lap_count = newest; 0 when not recalling
lap_count  output  $clog2(DEPTH+1)  entries held, saturates at DEPTH
buf_full  output  1  lap_count == DEPTH
valid  output  1  high in SHOW state

Behaviour:
- Reset (async, rst=1): both pointers 0, lap_count 0, state LIVE; all outputs 0. Storage contents need not be reset.
- Input priority in one cycle: clear > lap_store > recall_exit > recall_next.
- States: LIVE, SHOW.
- Writes:
  - lap_store writes storage[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0.
  - lap_count increments, saturating at DEPTH.
  - When full, the oldest entry is overwritten; lap_count stays DEPTH.
- LIVE:
  - tenth_sec_out, sec_out, lap_idx, valid all 0.
  - recall_next with lap_count > 0 -> SHOW, newest entry displayed next cycle: lap_idx = lap_count, valid = 1.
  - recall_next with lap_count == 0 is ignored.
- SHOW, recall_next: rd_ptr steps to the next older entry; lap_idx decrements.
  - From lap_idx 1, wraps to the newest (lap_idx = lap_count).
  - With lap_count 1, the display stays on the same entry.
- SHOW, recall_exit -> LIVE, outputs to 0 next cycle.
- SHOW, lap_store: entry is stored; display jumps to the new entry next cycle (lap_idx = new lap_count). This avoids showing an overwritten slot.
- clear, either state: lap_count 0, pointers 0, -> LIVE, outputs 0 next cycle.
- Latency: every output is registered and changes exactly 1 cycle after the causing pulse.
- Inputs are assumed already synchronised and debounced single-cycle pulses. Held-high levels step once per cycle.
- No arithmetic on stored data: values are stored and returned bit-exact.

Test Plan:
- Reset, then recall_next with empty buffer -> valid 0, lap_idx 0, lap_count 0.
- Store 12.3 s, 25.7 s, 40.1 s (sec/tenth 12/3, 25/7, 40/1); recall_next x4:
  - idx 3 (40/1), 2 (25/7), 1 (12/3), then wraps to 3 (40/1); lap_count 3.
- Store 10 laps with sec 1..10 (DEPTH 8):
  - lap_count 8, buf_full 1.
  - Recall shows newest sec 10 at idx 8; oldest reachable is sec 3 at idx 1.
- In SHOW at idx 1, pulse lap_store (sec 55, tenth 9) -> next cycle idx = lap_count, sec_out 55, tenth 9, valid 1.
- Same cycle clear + lap_store + recall_next with 3 laps held -> lap_count 0, LIVE, all outputs 0.
- Assert rst mid-SHOW asynchronously, between clock edges -> outputs 0 immediately; after release, recall_next is ignored (empty).
